fir_tcdm_arbiter: RTL
=====================

FIR_TCDM_ARBITER -- requirements
Module: fir_tcdm_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requester channels sharing one TCDM port (2..8).
REQ-002 SHALL have parameter OUTSTANDING, default 2, maximum granted transactions awaiting r_valid (1..4).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  synchronous reset, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous soft clear, active-high.
REQ-006 SHALL have ports in_req / in_gnt  input / output  N_REQ  per-requester request / grant.
REQ-007 SHALL have ports in_add, in_wen, in_be, in_data  input  N_REQ x {32,1,4,32}  per-requester request payload.
REQ-008 SHALL have ports in_r_data / in_r_valid  output  32 (shared) / N_REQ  response data broadcast; per-requester response valid.
REQ-009 SHALL have ports tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data  output  1,32,1,4,32  shared TCDM request.
REQ-010 SHALL have ports tcdm_gnt, tcdm_r_data, tcdm_r_valid  input  1,32,1  shared TCDM grant/response.
REQ-011 SHALL have port err_o  output  1  sticky flag: unexpected response.

Function
REQ-012 SHALL drive tcdm_req = (|in_req) AND (count < OUTSTANDING); payload muxed from the winner.
REQ-013 SHALL select the winner as the first asserted in_req at or after prio_ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-014 SHALL lock the winner while tcdm_req=1 and tcdm_gnt=0; the locked winner holds even if a higher-priority request arrives.
REQ-015 SHALL release the lock on the cycle tcdm_req AND tcdm_gnt; no lock if the locked requester drops in_req (lock cleared, re-arbitrate next cycle).
REQ-016 SHALL assert in_gnt[winner] = tcdm_gnt only when tcdm_req=1; all other in_gnt bits 0 (combinational).
REQ-017 SHALL, on each grant, push winner index into an ID FIFO of depth OUTSTANDING and set prio_ptr = (winner+1) mod N_REQ.
REQ-018 SHALL, on tcdm_r_valid with FIFO non-empty, pulse in_r_valid[head] for that cycle and pop; in_r_data = tcdm_r_data always.
REQ-019 SHALL treat every granted transaction (read or write) as returning exactly one r_valid, earliest the cycle after grant.
REQ-020 SHALL support simultaneous push and pop in one cycle; count unchanged.
REQ-021 SHALL block new requests when count = OUTSTANDING, even if a pop occurs the same cycle.
REQ-022 SHALL, on tcdm_r_valid with FIFO empty, assert no in_r_valid and set err_o until reset/clear.
REQ-023 SHALL, on clear_i=1, empty the FIFO, clear lock, reset prio_ptr to 0, clear err_o; tcdm_req forced 0 that cycle; responses after clear follow REQ-022.

Reset
REQ-024 SHALL, while rst_ni=0 at a clock edge, set prio_ptr=0, count=0, lock=0, err_o=0.
REQ-025 SHALL hold in_gnt=0, in_r_valid=0, tcdm_req=0 during reset, regardless of inputs.
REQ-026 SHALL apply reset mid-transaction identically; in-flight responses are then unexpected (REQ-022 after release).

Configuration
REQ-027 SHALL honour macro FIR_TCDM_ARB_ROUND_ROBIN_EN: defined, prio_ptr rotates per REQ-017.
REQ-028 SHALL, without FIR_TCDM_ARB_ROUND_ROBIN_EN, use fixed priority (index 0 highest); prio_ptr constant 0; lock and FIFO behaviour unchanged.

Verification
REQ-029 SHALL test: RR build, in_req=3'b111, tcdm_gnt=1 constant -> grants in order 0,1,2,0; tcdm_r_valid one cycle later routes to same indices.
REQ-030 SHALL test: in_req[1]=1, tcdm_gnt=0 for 3 cycles, in_req[0] rises cycle 2 -> tcdm_add stays in_add[1] until grant; then requester 2 (if requesting) else 0 next.
REQ-031 SHALL test: OUTSTANDING=2, two grants, no r_valid -> tcdm_req=0 on third cycle; one r_valid -> tcdm_req=1 next cycle.
REQ-032 SHALL test: tcdm_r_valid=1 with count=0, tcdm_r_data=0xDEADBEEF -> in_r_valid=0, err_o=1 and held; clear_i pulse -> err_o=0.
REQ-033 SHALL test: fixed-priority build, in_req=3'b110 continuous -> only requester 1 granted; in_req=3'b100 -> requester 2 granted.
REQ-034 SHALL test: rst_ni=0 with one transaction pending -> outputs 0 next cycle, count=0; late r_valid sets err_o.

Source files
------------

// File: rtl/fir_tcdm_arbiter.sv
// N-to-1 TCDM port arbiter with grant lock, outstanding-ID FIFO and response routing.
// Build option: FIR_TCDM_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise index 0 always wins.
module fir_tcdm_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [N_REQ-1:0]       in_req,
    output logic [N_REQ-1:0]       in_gnt,
    input  logic [N_REQ-1:0][31:0] in_add,
    input  logic [N_REQ-1:0]       in_wen,
    input  logic [N_REQ-1:0][3:0]  in_be,
    input  logic [N_REQ-1:0][31:0] in_data,
    output logic [31:0]            in_r_data,
    output logic [N_REQ-1:0]       in_r_valid,
    output logic                   tcdm_req,
    output logic [31:0]            tcdm_add,
    output logic                   tcdm_wen,
    output logic [3:0]             tcdm_be,
    output logic [31:0]            tcdm_data,
    input  logic                   tcdm_gnt,
    input  logic [31:0]            tcdm_r_data,
    input  logic                   tcdm_r_valid,
    output logic                   err_o
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    logic [IDX_W-1:0] prio_ptr;
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [IDX_W-1:0] id_mem [OUTSTANDING];

    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [SUM_W-1:0] cand;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] prio_nxt;
    logic [IDX_W-1:0] head;
    logic             active;
    logic             lock_hold;
    logic             grant;
    logic             pop;
    logic             unexpected;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // First asserted request at or after prio_ptr, wrapping around.
    always_comb begin
        arb_idx   = prio_ptr;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, prio_ptr} + SUM_W'(i);
            if (cand >= SUM_W'(N_REQ)) begin
                cand = cand - SUM_W'(N_REQ);
            end
            if (!arb_found && in_req[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign active     = rst_ni & ~clear_i;
    assign lock_hold  = lock_q & in_req[lock_idx_q];
    assign winner     = lock_hold ? lock_idx_q : arb_idx;
    assign tcdm_req   = active & (|in_req) & (count_q < CNT_W'(OUTSTANDING));
    assign grant      = tcdm_req & tcdm_gnt;
    assign pop        = active & tcdm_r_valid & (count_q != '0);
    assign unexpected = active & tcdm_r_valid & (count_q == '0);
    assign head       = id_mem[rd_ptr_q];

    assign tcdm_add   = in_add[winner];
    assign tcdm_wen   = in_wen[winner];
    assign tcdm_be    = in_be[winner];
    assign tcdm_data  = in_data[winner];
    assign in_r_data  = tcdm_r_data;

`ifdef FIR_TCDM_ARB_ROUND_ROBIN_EN
    assign prio_nxt = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
`else
    assign prio_nxt = '0;
`endif

    always_comb begin
        in_gnt     = '0;
        in_r_valid = '0;
        if (grant) begin
            in_gnt[winner] = 1'b1;
        end
        if (pop) begin
            in_r_valid[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            prio_ptr   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_o      <= 1'b0;
        end else begin
            // Lock holds the winner only while its request is stalled by the port.
            lock_q     <= tcdm_req & ~tcdm_gnt;
            lock_idx_q <= winner;
            if (grant) begin
                prio_ptr <= prio_nxt;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({grant, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (unexpected) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            id_mem[wr_ptr_q] <= winner;
        end
    end

endmodule
